// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, controller state encoding
// and a small opcode-class helper used by the controller and the ALU.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    // Eight-phase instruction ring plus a terminal halted state.
    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8
    } state_t;

    // Opcodes whose operand is fetched from memory and passed through the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational output decode for the machine controller: maps the current
// state, the live opcode and the ALU zero flag onto the datapath strobes.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [3:0] state,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       ena,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt
);

    // Strobes decode from state and opcode; a stall forces every strobe low
    // while halt keeps tracking the halted state.
    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        alu_ena     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = (state == HALTED);
        if (ena) begin
            case (state)
                S0: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                end
                S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S3: begin
                    if (opcode == OP_HLT) begin
                        halt = 1'b1;
                    end else begin
                        inc_pc = 1'b1;
                    end
                end
                S4: begin
                    if (is_alu_op(opcode)) begin
                        rd      = 1'b1;
                        alu_ena = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                    end else if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                    end
                end
                S5: begin
                    if (is_alu_op(opcode)) begin
                        rd       = 1'b1;
                        load_acc = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        load_pc = 1'b1;
                        inc_pc  = 1'b1;
                    end else if (opcode == OP_STO) begin
                        wr          = 1'b1;
                        datactl_ena = 1'b1;
                    end
                end
                S6: begin
                    if (opcode == OP_STO) begin
                        datactl_ena = 1'b1;
                    end
                end
                S7: begin
                    if (opcode == OP_SKZ) begin
                        inc_pc = zero;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/machine_ctrl.sv
// Machine controller: eight-phase instruction sequencer with a terminal
// halted state and a wrapping count of completed instructions.
module machine_ctrl
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       rd,
    output logic       wr,
    output logic       load_ir,
    output logic       alu_ena,
    output logic       load_acc,
    output logic       datactl_ena,
    output logic       halt,
    output logic [7:0] instr_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;

    // State register and instruction counter; the counter steps when the
    // ring leaves S7, i.e. when an instruction completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if (ena && (state_q == S7)) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    // Next state: hold on stall or when halted, leave the ring on HLT at S3,
    // otherwise advance one phase with S7 wrapping to S0.
    always_comb begin
        state_d = state_q;
        if (ena && (state_q != HALTED)) begin
            if ((state_q == S3) && (opcode == OP_HLT)) begin
                state_d = HALTED;
            end else if (state_q == S7) begin
                state_d = S0;
            end else begin
                state_d = state_t'(state_q + 4'd1);
            end
        end
    end

    ctrl_decode u_decode (
        .state       (state_q),
        .opcode      (opcode),
        .zero        (zero),
        .ena         (ena),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .alu_ena     (alu_ena),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_machine_ctrl.sv
// Bench for machine_ctrl: directed instruction scenarios followed by random
// traffic, all checked every cycle against a phase/counter reference model.
module tb_machine_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc, load_pc, rd, wr, load_ir, alu_ena, load_acc, datactl_ena, halt;
    logic [7:0] instr_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: instruction phase 0..7, halted flag, completed count
    int m_phase  = 0;
    bit m_halted = 1'b0;
    int m_cnt    = 0;
    bit m_valid  = 1'b0;

    machine_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .opcode      (opcode),
        .zero        (zero),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .alu_ena     (alu_ena),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs, packed as
    // {inc_pc, load_pc, rd, wr, load_ir, alu_ena, load_acc, datactl_ena, halt}
    function automatic logic [8:0] exp_outs(input int ph, input bit hlt, input logic e,
                                            input logic [2:0] op, input logic z);
        bit i_pc = 0, l_pc = 0, r = 0, w = 0, l_ir = 0, a_en = 0, l_acc = 0, d_en = 0, h = 0;
        bit is_alu;
        is_alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        if (hlt) begin
            h = 1;
        end else if (e) begin
            if (ph == 0 || ph == 1) begin r = 1; l_ir = 1; end
            if (ph == 1) i_pc = 1;
            if (ph == 3) begin
                if (op == 3'd0) h = 1; else i_pc = 1;
            end
            if (ph == 4 || ph == 5) begin
                if (is_alu) r = 1;
                if (op == 3'd7) l_pc = 1;
                if (op == 3'd6) d_en = 1;
            end
            if (ph == 4 && is_alu) a_en = 1;
            if (ph == 5 && is_alu) l_acc = 1;
            if (ph == 5 && op == 3'd7) i_pc = 1;
            if (ph == 5 && op == 3'd6) w = 1;
            if (ph == 6 && op == 3'd6) d_en = 1;
            if (ph == 7 && op == 3'd1) i_pc = z;
        end
        return {i_pc, l_pc, r, w, l_ir, a_en, l_acc, d_en, h};
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model.
    task automatic cycle(input logic r, input logic e, input logic [2:0] op, input logic z);
        rst = r; ena = e; opcode = op; zero = z;
        #1;
        if (m_valid) begin
            check("outs", {7'd0, inc_pc, load_pc, rd, wr, load_ir, alu_ena, load_acc, datactl_ena, halt},
                  {7'd0, exp_outs(m_phase, m_halted, e, op, z)});
            check("instr_cnt", {8'd0, instr_cnt}, m_cnt[15:0]);
            check("wr_rd_excl", {15'd0, wr & (rd | load_ir)}, 16'd0);
        end
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_halted = 0; m_cnt = 0; m_valid = 1;
        end else if (!m_halted && e) begin
            if (m_phase == 3 && op == 3'd0) begin
                m_halted = 1;
            end else begin
                if (m_phase == 7) m_cnt = (m_cnt + 1) % 256;
                m_phase = (m_phase + 1) % 8;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [2:0] op, input logic z);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, op, z);
    endtask

    initial begin
        // reset then ADD
        cycle(1'b1, 1'b1, 3'd2, 1'b0);
        #1;
        check("reset_rd", {15'd0, rd}, 16'd1);
        check("reset_load_ir", {15'd0, load_ir}, 16'd1);
        check("reset_halt", {15'd0, halt}, 16'd0);
        check("reset_cnt", {8'd0, instr_cnt}, 16'd0);
        run_instr(3'd2, 1'b0);
        check("add_cnt", {8'd0, instr_cnt}, 16'd1);

        // STO, SKZ with both zero values, the remaining ALU opcodes
        run_instr(3'd6, 1'b0);
        run_instr(3'd1, 1'b1);
        run_instr(3'd1, 1'b0);
        run_instr(3'd3, 1'b0);
        run_instr(3'd4, 1'b1);
        run_instr(3'd5, 1'b0);

        // stall at S4 for 5 cycles, then resume
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 3'd2, 1'b0);
        #1;
        check("stall_hold_alu_ena", {15'd0, alu_ena}, 16'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd2, 1'b0);

        // reset arriving at S5
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'd2, 1'b0);
        cycle(1'b1, 1'b1, 3'd2, 1'b0);
        #1;
        check("midrst_cnt", {8'd0, instr_cnt}, 16'd0);
        check("midrst_load_ir", {15'd0, load_ir}, 16'd1);

        // HLT, 20 halted cycles with arbitrary inputs, then reset exit
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        #1;
        check("halted_halt", {15'd0, halt}, 16'd1);
        cycle(1'b1, 1'b1, 3'd0, 1'b0);
        #1;
        check("halt_exit_halt", {15'd0, halt}, 16'd0);

        // 256 JMP instructions: counter wraps back to zero
        for (int i = 0; i < 256; i++) run_instr(3'd7, 1'b0);
        check("wrap_cnt", {8'd0, instr_cnt}, 16'd0);

        // random traffic with stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 8),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
